// File: rtl/resp_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Latency: none (package only).
// Backpressure: none.
package resp_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    localparam logic [31:0] RESP_MMIO_BASE = 32'hBFAF_0000;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_SCRATCH = 16'h000C;

    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_dat,
        input logic [WORD_W-1:0] new_dat,
        input logic [STRB_W-1:0] strb
    );
        logic [WORD_W-1:0] res;
        res = old_dat;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bram_1p.sv
// Single-port 2^AW x 32 RAM with byte enables and a registered read-first output.
// Latency: read data one cycle after en; a write cycle returns the old word.
// Backpressure: none, accepts an access every cycle; reset only clears the output register.
module sram_bram_1p
    import resp_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic [STRB_W-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**AW];

    // Writes sit in the non-reset branch so a request during reset leaves memory intact.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < STRB_W; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// CPU data SRAM target: RAM plus MMIO window (LED, SWITCH, TIMER, SCRATCH). Macro RESP_TIMER_EN enables the timer.
// Latency: fixed 1 cycle read, read-first on writes; rdata holds when en=0.
// Backpressure: none, every request is accepted; requests in a reset cycle are dropped.
module data_sram_responder
    import resp_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] MMIO_BASE = RESP_MMIO_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    logic        mmio_hit;
    logic [15:0] offset;
    logic        mmio_wr;
    logic [31:0] mmio_rd;
    logic [31:0] led_merge;
    logic [31:0] scratch_merge;
    logic [31:0] timer_val;
    logic [31:0] scratch;
    logic [7:0]  switch_q;
    logic        mmio_hit_q;
    logic [31:0] mmio_rdata_q;
    logic [31:0] ram_rdata;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^data_sram_addr[1:0];

    assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign offset   = {data_sram_addr[15:2], 2'b00};
    assign mmio_wr  = data_sram_en && mmio_hit && (data_sram_we != 4'b0000);

    assign led_merge     = byte_merge({16'h0000, led}, data_sram_wdata, data_sram_we);
    assign scratch_merge = byte_merge(scratch, data_sram_wdata, data_sram_we);

    always_comb begin
        mmio_rd = '0;
        case (offset)
            OFF_LED:     mmio_rd = {16'h0000, led};
            OFF_SWITCH:  mmio_rd = {24'h000000, switch_q};
            OFF_TIMER:   mmio_rd = timer_val;
            OFF_SCRATCH: mmio_rd = scratch;
            default:     mmio_rd = '0;
        endcase
    end

    sram_bram_1p #(.AW(RAM_AW)) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .en     (data_sram_en && !mmio_hit),
        .we     (data_sram_we),
        .addr   (data_sram_addr[RAM_AW+1:2]),
        .wdata  (data_sram_wdata),
        .rdata  (ram_rdata)
    );

    // MMIO read data is captured at request time so it is read-first like the RAM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led          <= '0;
            scratch      <= '0;
            switch_q     <= '0;
            mmio_hit_q   <= 1'b0;
            mmio_rdata_q <= '0;
        end else begin
            switch_q <= switch;
            if (data_sram_en) begin
                mmio_hit_q <= mmio_hit;
                if (mmio_hit) mmio_rdata_q <= mmio_rd;
            end
            if (mmio_wr && offset == OFF_LED)     led     <= led_merge[15:0];
            if (mmio_wr && offset == OFF_SCRATCH) scratch <= scratch_merge;
        end
    end

`ifdef RESP_TIMER_EN
    logic [31:0] timer;
    logic [31:0] timer_merge;

    assign timer_merge = byte_merge(timer, data_sram_wdata, data_sram_we);
    assign timer_val   = timer;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer <= '0;
        end else if (mmio_wr && offset == OFF_TIMER) begin
            timer <= timer_merge;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    assign timer_val = '0;
`endif

    assign data_sram_rdata = mmio_hit_q ? mmio_rdata_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised bench for data_sram_responder against a cycle-level behavioural model.
// Latency: checks rdata one cycle after each request; Backpressure: not applicable.
// Honours RESP_TIMER_EN to choose the timer model.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_scratch;
    logic [31:0] m_timer;
    logic [7:0]  m_swq;
    logic [31:0] m_rdata;

    data_sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .switch          (switch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] apply_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] we);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = we[k] ? new_w[k*8 +: 8] : old_w[k*8 +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return a[31:16] == 16'hBFAF;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int idx;
        if (is_mmio(a)) begin
            case (int'(a[15:0]) / 4)
                0: return {16'h0, m_led};
                1: return {24'h0, m_swq};
`ifdef RESP_TIMER_EN
                2: return m_timer;
`endif
                3: return m_scratch;
                default: return 32'h0;
            endcase
        end
        idx = int'(a[15:2]);
        if (m_mem.exists(idx)) return m_mem[idx];
        return 32'h0;
    endfunction

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input logic rn, input logic en, input logic [3:0] we,
                        input logic [31:0] a, input logic [31:0] wd);
        int idx;
        int slot;
        bit timer_loaded;
        resetn = rn; data_sram_en = en; data_sram_we = we;
        data_sram_addr = a; data_sram_wdata = wd;
        @(posedge clk);
        #1;
        timer_loaded = 0;
        if (!rn) begin
            m_led = 0; m_scratch = 0; m_timer = 0; m_swq = 0; m_rdata = 0;
        end else begin
            if (en) begin
                m_rdata = model_read(a);
                if (we != 4'b0) begin
                    if (is_mmio(a)) begin
                        slot = int'(a[15:0]) / 4;
                        if (slot == 0) m_led = apply_bytes({16'h0, m_led}, wd, we) & 32'hFFFF;
                        if (slot == 3) m_scratch = apply_bytes(m_scratch, wd, we);
`ifdef RESP_TIMER_EN
                        if (slot == 2) begin
                            m_timer = apply_bytes(m_timer, wd, we);
                            timer_loaded = 1;
                        end
`endif
                    end else begin
                        idx = int'(a[15:2]);
                        m_mem[idx] = apply_bytes(m_mem.exists(idx) ? m_mem[idx] : 32'h0, wd, we);
                    end
                end
            end
            if (!timer_loaded) m_timer = m_timer + 1;
            m_swq = switch;
        end
        chk("rdata", data_sram_rdata, m_rdata);
        chk("led", {16'h0, led}, {16'h0, m_led});
    endtask

    localparam logic [31:0] LED_A  = 32'hBFAF_0000;
    localparam logic [31:0] SW_A   = 32'hBFAF_0004;
    localparam logic [31:0] TMR_A  = 32'hBFAF_0008;
    localparam logic [31:0] SCR_A  = 32'hBFAF_000C;

    initial begin
        logic [31:0] a;
        logic [15:0] offs [6];
        int pool [8];
        logic [31:0] t0;

        switch = 8'h00;
        m_led = 0; m_scratch = 0; m_timer = 0; m_swq = 0; m_rdata = 0;
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("reset_rdata", data_sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);

        // Store / load
        step(1, 1, 4'hF, 32'h0000_0100, 32'hDEADBEEF);
        step(1, 1, 4'h0, 32'h0000_0100, 32'h0);
        chk("t1_load", data_sram_rdata, 32'hDEADBEEF);

        // Byte strobes
        step(1, 1, 4'hF, 32'h0000_0200, 32'h11223344);
        step(1, 1, 4'b0101, 32'h0000_0200, 32'hAABBCCDD);
        step(1, 1, 4'h0, 32'h0000_0200, 32'h0);
        chk("t2_strobe", data_sram_rdata, 32'h11BB33DD);

        // Read-first, plus aliasing of upper address bits
        step(1, 1, 4'hF, 32'h0000_0300, 32'h0);
        step(1, 1, 4'hF, 32'h0000_0300, 32'h55);
        chk("t3_readfirst", data_sram_rdata, 32'h0);
        step(1, 1, 4'h0, 32'h1234_0300, 32'h0);
        chk("t3_after", data_sram_rdata, 32'h55);

        // MMIO LED and SWITCH
        step(1, 1, 4'hF, LED_A, 32'h0001_ABCD);
        chk("t4_led", {16'h0, led}, 32'h0000_ABCD);
        step(1, 1, 4'h0, LED_A, 32'h0);
        chk("t4_led_rd", data_sram_rdata, 32'h0000_ABCD);
        switch = 8'h5A;
        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(1, 1, 4'hF, SW_A, 32'hFFFF_FFFF);
        step(1, 1, 4'h0, SW_A, 32'h0);
        chk("t4_switch", data_sram_rdata, 32'h0000_005A);
        step(1, 1, 4'h0, 32'hBFAF_0040, 32'h0);
        chk("t4_unmapped", data_sram_rdata, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        chk("t4_hold", data_sram_rdata, 32'h0);

        // Timer wrap
        step(1, 1, 4'hF, TMR_A, 32'hFFFF_FFFE);
`ifdef RESP_TIMER_EN
        t0 = 32'hFFFF_FFFE;
`else
        t0 = 32'h0;
`endif
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 4'h0, TMR_A, 32'h0);
`ifdef RESP_TIMER_EN
            chk("t5_timer", data_sram_rdata, t0 + k);
`else
            chk("t5_timer", data_sram_rdata, t0);
`endif
        end

        // Reset in the middle of writes
        step(1, 1, 4'hF, SCR_A, 32'h0000_1234);
        step(1, 1, 4'hF, 32'h0000_0400, 32'h77);
        step(0, 1, 4'hF, SCR_A, 32'h9999_9999);
        step(0, 1, 4'hF, 32'h0000_0400, 32'h99);
        chk("t6_led", {16'h0, led}, 32'h0);
        chk("t6_rdata", data_sram_rdata, 32'h0);
        step(1, 1, 4'h0, SCR_A, 32'h0);
        chk("t6_scratch", data_sram_rdata, 32'h0);
        step(1, 1, 4'h0, 32'h0000_0400, 32'h0);
        chk("t6_ram", data_sram_rdata, 32'h77);

        // Random traffic over a small RAM pool and the MMIO window
        offs[0] = 16'h0000; offs[1] = 16'h0004; offs[2] = 16'h0008;
        offs[3] = 16'h000C; offs[4] = 16'h0010; offs[5] = 16'h0040;
        for (int k = 0; k < 8; k++) begin
            pool[k] = 16'h1000 + k * 37;
            step(1, 1, 4'hF, {16'h0, pool[k][13:0], 2'b00}, $urandom);
        end
        for (int n = 0; n < 600; n++) begin
            switch = 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                a = {16'hBFAF, offs[$urandom_range(0, 5)][15:2], 2'($urandom)};
            else
                a = {1'b0, 15'($urandom), pool[$urandom_range(0, 7)][13:0], 2'($urandom)};
            step(($urandom_range(0, 49) != 0), 1'($urandom), 4'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
